// File: rtl/phys_reg_free_list_pkg.sv
// Free-list sizing constants and the retire-side return bundle type.
// No logic; latency and backpressure are not applicable.
package phys_reg_free_list_pkg;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_BITS = $clog2(NUM_PREGS);
    localparam int ALLOC_W   = 2;
    localparam int FREE_W    = 2;
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int RC_W      = $clog2(ALLOC_W + 1);

    typedef struct {
        logic                 valid [FREE_W];
        logic [PREG_BITS-1:0] preg  [FREE_W];
    } freeListReqStruct;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/retire side bus of the physical-register free list.
// Alloc results are combinational; a request that cannot be fully served is refused (all-or-nothing).
interface phys_reg_free_list_if;
    import phys_reg_free_list_pkg::*;

    logic [ALLOC_W-1:0]           alloc_req;
    logic                         alloc_grant;
    logic [ALLOC_W*PREG_BITS-1:0] alloc_preg;
    logic [FREE_W-1:0]            free_valid;
    logic [FREE_W*PREG_BITS-1:0]  free_preg;
    logic [RC_W-1:0]              retire_cnt;
    logic                         flush;
    logic [CNT_W-1:0]             free_count;
    logic                         empty;
    logic                         err;

    modport master (
        output alloc_req, free_valid, free_preg, retire_cnt, flush,
        input  alloc_grant, alloc_preg, free_count, empty, err
    );
    modport slave (
        input  alloc_req, free_valid, free_preg, retire_cnt, flush,
        output alloc_grant, alloc_preg, free_count, empty, err
    );
endinterface

// File: rtl/phys_reg_free_list_lane_compactor.sv
// Prefix popcount of a lane mask: per-lane offset among set lanes plus total.
// Purely combinational, no backpressure.
module lane_compactor #(
    parameter  int W  = 2,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         mask,
    output logic [W-1:0][CW-1:0] offset,
    output logic [CW-1:0]        total
);
    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < W; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(mask[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free pool of pregs with speculative and retired heads; flush rewinds in one cycle.
// Alloc is combinational, frees become allocatable next cycle; short pool refuses the whole request.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    phys_reg_free_list_if.slave bus
);
    localparam int CW_A = $clog2(ALLOC_W + 1);
    localparam int CW_F = $clog2(FREE_W + 1);
    localparam int NW   = CNT_W + 2;

    logic [PREG_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     head, arch_head, tail;
    logic [CNT_W-1:0]     free_count;
    logic                 err_q;

    logic [ALLOC_W-1:0][CW_A-1:0] a_off;
    logic [CW_A-1:0]              n_req;
    logic [FREE_W-1:0][CW_F-1:0]  f_off;
    logic [CW_F-1:0]              n_free;
    freeListReqStruct             fr;

    logic             grant;
    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] outstanding, arch_next, head_next, returned;
    logic             retire_err, overflow;
    logic [NW-1:0]    fc_next;

    lane_compactor #(.W(ALLOC_W)) u_alloc_cmp (.mask(bus.alloc_req),  .offset(a_off), .total(n_req));
    lane_compactor #(.W(FREE_W))  u_free_cmp  (.mask(bus.free_valid), .offset(f_off), .total(n_free));

    always_comb begin
        for (int i = 0; i < FREE_W; i++) begin
            fr.valid[i] = bus.free_valid[i];
            fr.preg[i]  = bus.free_preg[i*PREG_BITS +: PREG_BITS];
        end
    end

    assign grant = !bus.flush && (free_count >= CNT_W'(n_req));

    always_comb begin
        bus.alloc_preg = '0;
        rd_idx         = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (bus.alloc_req[i]) begin
                rd_idx = head + PTR_W'(a_off[i]);
                bus.alloc_preg[i*PREG_BITS +: PREG_BITS] = mem[rd_idx];
            end
        end
    end

    // Retire is applied before flush so a flush rewinds only to the newly committed point.
    always_comb begin
        outstanding = head - arch_head;
        retire_err  = CNT_W'(bus.retire_cnt) > CNT_W'(outstanding);
        arch_next   = retire_err ? head : arch_head + PTR_W'(bus.retire_cnt);
        head_next   = bus.flush ? arch_next : (grant ? head + PTR_W'(n_req) : head);
        returned    = bus.flush ? head - arch_next : '0;
        fc_next     = NW'(free_count) - (grant ? NW'(n_req) : '0) + NW'(n_free) + NW'(returned);
        overflow    = fc_next > NW'(DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_BITS'(NUM_AREGS + i);
            head       <= '0;
            arch_head  <= '0;
            tail       <= '0;
            free_count <= CNT_W'(DEPTH);
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < FREE_W; i++) begin
                if (fr.valid[i]) mem[tail + PTR_W'(f_off[i])] <= fr.preg[i];
            end
            tail       <= tail + PTR_W'(n_free);
            head       <= head_next;
            arch_head  <= arch_next;
            free_count <= fc_next[CNT_W-1:0];
            if (retire_err || overflow) err_q <= 1'b1;
        end
    end

    assign bus.alloc_grant = grant;
    assign bus.free_count  = free_count;
    assign bus.empty       = (free_count == '0);
    assign bus.err         = err_q;
endmodule
